// File: rtl/tick_pkg.sv
// Shared constants for the multi-channel tick generator: parameter defaults
// and the per-channel mode encoding.
package tick_pkg;

  localparam int CNT_W_DEF       = 20;
  localparam int DEFAULT_DIV_DEF = 1_000_000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_gen_multi_if.sv
// Control/status bundle of tick_gen_multi: per-channel run/clear/mode,
// the divisor write port and the per-channel tick/done/busy flags.
interface tick_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] clear;
  logic [NUM_CH-1:0] oneshot;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] o_tick;
  logic [NUM_CH-1:0] o_done;
  logic [NUM_CH-1:0] o_busy;

  modport master (
    output run, clear, oneshot, cfg_we, cfg_ch, cfg_div,
    input  o_tick, o_done, o_busy
  );

  modport slave (
    input  run, clear, oneshot, cfg_we, cfg_ch, cfg_div,
    output o_tick, o_done, o_busy
  );

endinterface

// File: rtl/tick_chan.sv
// One tick channel: programmable divisor, counter, registered tick and a
// sticky one-shot done flag, with clear > cfg write > done hold > run.
module tick_chan
  import tick_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clear,
  input  logic             oneshot,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  // A divisor of 0 is treated as 1, so both terminate at count 0.
  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] div_reg, div_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             tick_q, tick_nxt;
  logic             done_q, done_nxt;

  always_comb begin
    div_nxt   = div_reg;
    count_nxt = count;
    tick_nxt  = 1'b0;
    done_nxt  = done_q;
    if (clear) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (cfg_wr) begin
      div_nxt   = cfg_div;
      count_nxt = '0;
    end else if (done_q) begin
      count_nxt = '0;
    end else if (run) begin
      if (count == last_count(div_reg)) begin
        count_nxt = '0;
        tick_nxt  = 1'b1;
        if (mode_e'(oneshot) == MODE_ONESHOT) done_nxt = 1'b1;
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= CNT_W'(DEFAULT_DIV);
      count   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_reg <= div_nxt;
      count   <= count_nxt;
      tick_q  <= tick_nxt;
      done_q  <= done_nxt;
    end
  end

  assign tick = tick_q;
  assign done = done_q;
  assign busy = run & ~done_q & ~clear;

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent tick channels sharing one divisor write port; the write
// strobe is decoded per channel and out-of-range indices match no channel.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  tick_gen_multi_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] cfg_wr;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] done_v;
  logic [NUM_CH-1:0] busy_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_wr[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    tick_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (bus.run[i]),
      .clear   (bus.clear[i]),
      .oneshot (bus.oneshot[i]),
      .cfg_wr  (cfg_wr[i]),
      .cfg_div (bus.cfg_div),
      .tick    (tick_v[i]),
      .done    (done_v[i]),
      .busy    (busy_v[i])
    );
  end

  assign bus.o_tick = tick_v;
  assign bus.o_done = done_v;
  assign bus.o_busy = busy_v;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: per-cycle vector tables for one-shot and
// divisor corner cases, hand sequences for reset, periodic, pause and independence.
module tb_tick_gen_multi;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tick_gen_multi_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  tick_gen_multi #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEFAULT_DIV (5)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         ch;
    logic       run;
    logic       clr;
    logic       os;
    logic       we;
    logic [7:0] div;
    logic       et;
    logic       ed;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input logic [7:0] d);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'(ch);
    bus.cfg_div = d;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic addv(input int ch, input logic r, input logic c, input logic o,
                      input logic w, input logic [7:0] d,
                      input logic et, input logic ed, input logic eb);
    vec_t v;
    v.ch = ch; v.run = r; v.clr = c; v.os = o; v.we = w; v.div = d;
    v.et = et; v.ed = ed; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      bus.run     = '0;
      bus.clear   = '0;
      bus.oneshot = '0;
      bus.run[vq[i].ch]     = vq[i].run;
      bus.clear[vq[i].ch]   = vq[i].clr;
      bus.oneshot[vq[i].ch] = vq[i].os;
      bus.cfg_we  = vq[i].we;
      bus.cfg_ch  = 2'(vq[i].ch);
      bus.cfg_div = vq[i].div;
      step();
      chk($sformatf("%s[%0d] tick", tag, i), 32'(bus.o_tick[vq[i].ch]), 32'(vq[i].et));
      chk($sformatf("%s[%0d] done", tag, i), 32'(bus.o_done[vq[i].ch]), 32'(vq[i].ed));
      chk($sformatf("%s[%0d] busy", tag, i), 32'(bus.o_busy[vq[i].ch]), 32'(vq[i].eb));
    end
    vq.delete();
    bus.cfg_we  = 1'b0;
    bus.run     = '0;
    bus.clear   = '0;
    bus.oneshot = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    int base;
    int d2;
    logic [3:0] et;

    bus.run = '0; bus.clear = '0; bus.oneshot = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;

    // Reset values, then a tick in progress killed by an asynchronous reset.
    repeat (3) step();
    chk("rst tick", 32'(bus.o_tick), 32'h0);
    chk("rst done", 32'(bus.o_done), 32'h0);
    chk("rst busy", 32'(bus.o_busy), 32'h0);
    reset_n = 1'b1;
    bus.oneshot = 4'b1000;
    bus.run = 4'hF;
    for (int s = 1; s <= 5; s++) begin
      step();
      chk($sformatf("default div s%0d", s), 32'(bus.o_tick), (s == 5) ? 32'hF : 32'h0);
    end
    chk("oneshot ch3 done pre-reset", 32'(bus.o_done), 32'h8);
    bus.run = 4'hF;
    for (int s = 1; s <= 3; s++) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async rst tick", 32'(bus.o_tick), 32'h0);
    chk("async rst done", 32'(bus.o_done), 32'h0);
    bus.run = '0;
    bus.oneshot = '0;
    #1;
    chk("async rst busy", 32'(bus.o_busy), 32'h0);
    reset_n = 1'b1;
    bus.run = 4'b0001;
    for (int s = 1; s <= 7; s++) begin
      step();
      chk($sformatf("post-rst ch0 s%0d", s), 32'(bus.o_tick[0]), 32'(s == 5));
    end
    bus.run = '0;

    // Periodic ch1, divisor 4.
    cfg(1, 8'd4);
    bus.run = 4'b0010;
    nt = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      chk($sformatf("periodic ch1 s%0d", s), 32'(bus.o_tick[1]), 32'((s % 4) == 0));
      if (bus.o_tick[1]) nt++;
    end
    chk("periodic ch1 count", 32'(nt), 32'd5);
    bus.run = '0;

    // One-shot ch2, divisor 3.
    addv(2, 0, 0, 1, 1, 8'd3, 0, 0, 0);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 1, 1, 0);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 1, 0);
    run_table("oneshot");
    bus.run = 4'b0100;
    bus.oneshot = 4'b0100;
    nt = 0;
    for (int s = 0; s < 50; s++) begin
      step();
      if (bus.o_tick[2]) nt++;
    end
    chk("oneshot extra ticks", 32'(nt), 32'd0);
    chk("oneshot held done", 32'(bus.o_done[2]), 32'd1);
    chk("oneshot held busy", 32'(bus.o_busy[2]), 32'd0);
    addv(2, 1, 1, 1, 0, 8'd0, 0, 0, 0);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 1, 1, 0);
    addv(2, 1, 0, 0, 0, 8'd0, 0, 1, 0);
    addv(2, 1, 0, 0, 0, 8'd0, 0, 1, 0);
    addv(2, 0, 1, 0, 0, 8'd0, 0, 0, 0);
    addv(2, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 0, 0, 1);
    addv(2, 1, 0, 1, 0, 8'd0, 1, 1, 0);
    addv(2, 0, 1, 0, 0, 8'd0, 0, 0, 0);
    run_table("rearm");

    // Divisor 0 and 1 on ch3, and a write landing on the terminal count.
    addv(3, 1, 0, 0, 1, 8'd0, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 1, 8'd1, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    addv(3, 1, 0, 0, 1, 8'd3, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(3, 1, 0, 0, 1, 8'd3, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 0, 0, 1);
    addv(3, 1, 0, 0, 0, 8'd0, 1, 0, 1);
    run_table("divedge");

    // Pause/resume and clear at the terminal count on ch0, divisor 10.
    cfg(0, 8'd10);
    bus.run = 4'b0001;
    nt = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (bus.o_tick[0]) nt++;
    end
    bus.run = '0;
    for (int s = 0; s < 7; s++) begin
      step();
      if (bus.o_tick[0]) nt++;
    end
    chk("pause no tick", 32'(nt), 32'd0);
    chk("pause busy", 32'(bus.o_busy[0]), 32'd0);
    bus.run = 4'b0001;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("resume s%0d", s), 32'(bus.o_tick[0]), 32'(s == 4));
    end
    for (int s = 0; s < 9; s++) step();
    bus.clear = 4'b0001;
    step();
    chk("clear at terminal tick", 32'(bus.o_tick[0]), 32'd0);
    chk("clear busy", 32'(bus.o_busy[0]), 32'd0);
    bus.clear = '0;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk($sformatf("after clear s%0d", s), 32'(bus.o_tick[0]), 32'(s == 10));
    end
    bus.run = '0;

    // All channels running while ch2 is reprogrammed.
    cfg(0, 8'd2);
    cfg(1, 8'd3);
    cfg(2, 8'd4);
    cfg(3, 8'd5);
    bus.clear = 4'hF;
    step();
    bus.clear = '0;
    bus.run = 4'hF;
    base = 0;
    d2 = 4;
    for (int s = 1; s <= 30; s++) begin
      if (s == 10) begin
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 8'd3;
      end
      step();
      bus.cfg_we = 1'b0;
      et[0] = (s % 2) == 0;
      et[1] = (s % 3) == 0;
      et[3] = (s % 5) == 0;
      if (s == 10) begin
        et[2] = 1'b0;
        base = 10;
        d2 = 3;
      end else begin
        et[2] = ((s - base) % d2) == 0;
      end
      chk($sformatf("indep s%0d", s), 32'(bus.o_tick), 32'(et));
    end
    bus.run = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel, parametrised tick generator: the next generation of the single 100 Hz tick divider. Each of NUM_CH channels divides the system clock by its own runtime-programmable divisor and emits a one-cycle registered tick. Channels run in periodic or one-shot mode with per-channel run/clear. The block feeds stopwatch, watch and debounce timing in the same design from one instance.

## Interface
- NUM_CH, 4, number of independent tick channels (≥1)
- CNT_W, 20, counter/divisor width in bits
- DEFAULT_DIV, 1_000_000, divisor loaded into every channel at reset (must satisfy 1 ≤ DEFAULT_DIV < 2^CNT_W)
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- run  input  NUM_CH  per-channel count enable, level-sensitive
- clear  input  NUM_CH  per-channel synchronous counter/state clear, level-sensitive
- oneshot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic; sampled every cycle
- cfg_we  input  1  divisor write strobe, one cycle
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for the divisor write
- cfg_div  input  CNT_W  new divisor value
- o_tick  output  NUM_CH  registered one-cycle tick pulse per channel
- o_done  output  NUM_CH  one-shot completion flag, sticky until clear
- o_busy  output  NUM_CH  channel counting this cycle: run & ~o_done & ~clear

## Operation
- Per channel state: div_reg (CNT_W), count (CNT_W), tick (1), done (1).
- Effective divisor: div_eff = (div_reg == 0) ? 1 : div_reg; divisor 0 behaves exactly as 1.
- Priority per channel, highest first: clear, cfg write to this channel, done hold, run, idle.
- clear=1: count←0, tick←0, done←0. Divisor unchanged.
- cfg_we=1 and cfg_ch==i (no clear): div_reg←cfg_div, count←0, tick←0. done is unchanged. A cfg_ch ≥ NUM_CH is ignored.
- done=1 (one-shot finished): count and tick hold at 0 until clear, regardless of run.
- run=1: if count == div_eff−1, then count←0 and tick←1; in one-shot mode also done←1. Otherwise count←count+1 and tick←0.
- run=0: count holds (pause/resume), tick←0.
- Changing oneshot mid-count takes effect at the next terminal count. Clearing oneshot while done=1 does not clear done; clear is required.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (reset_n=0, asynchronous): count=0, tick=0, done=0, div_reg=DEFAULT_DIV. Therefore o_tick=0, o_done=0, o_busy=0 while run is low.
- Tick latency: o_tick rises one cycle after the cycle in which count==div_eff−1 with run=1, and stays high exactly one cycle.
- Periodic run from count 0 with run held high: first tick on cycle div_eff after run rises, then one tick every div_eff cycles.
- div_eff=1 with run high: o_tick is high every cycle (periodic) or exactly once (one-shot).
- o_done rises in the same cycle as the final o_tick.
- Divisor write: the new value applies from the following cycle and count restarts at 0. A terminal count in the write cycle is discarded; no tick follows.
- clear asserted in the terminal cycle: no tick is issued.
- reset_n deasserted mid-count: all channels return to reset values immediately. Release is synchronous to clk in the surrounding design.

## Structure
- Shared package tick_pkg holds the DEFAULT_DIV default, the CNT_W default and the mode encoding constants (MODE_PERIODIC=0, MODE_ONESHOT=1).
- One sub-module, tick_chan, implements a single channel: div_reg, count, tick, done and the priority logic.
- The top level instantiates NUM_CH copies in a generate loop and decodes cfg_we/cfg_ch into a per-channel write strobe.

## Test plan
- Reset: drive reset_n=0 with run=all ones mid-count. Required: o_tick=0, o_done=0 and counts=0 immediately; after release, ch0 with DEFAULT_DIV=5 ticks on cycle 5.
- Periodic: write div=4 to ch1 and hold run[1]=1 for 20 cycles. Required: exactly 5 one-cycle ticks, spaced 4 cycles apart; the first tick falls 4 cycles after run rises.
- One-shot: ch2 div=3, oneshot=1, run held high. Required: a single tick on cycle 3 with o_done=1 in the same cycle, no further ticks for 50 cycles, o_busy=0. A one-cycle clear re-arms the channel and the next tick arrives 3 cycles later.
- Pause/clear: ch0 div=10; drop run after 6 cycles for 7 cycles, then resume. Required: tick at 4 cycles after resume. Assert clear and run together at the terminal count. Required: no tick and count=0.
- Divisor edge cases: write div=0 and then div=1 to ch3 with run high. Required: a tick every cycle in both cases. A write in the terminal cycle restarts count at 0 with no tick.
- Channel independence: all 4 channels run with divs 2/3/4/5 while cfg writes to cfg_ch=2 go out. Required: ch0, ch1 and ch3 tick periods are unaffected, and ch2 restarts from the write.
